// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard interface blocks:
//   - state_t     : host transmitter state encoding
//   - FRAME_BITS  : bits shifted out after the start bit (8 data, parity, stop)
//   - CMD_*       : common host-to-keyboard command bytes
//   - ACK_BYTE    : byte the keyboard answers with on the receive path
//   - odd_parity  : parity bit that makes data plus parity hold an odd number
//                   of ones
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  localparam int FRAME_BITS = 10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
// Two-flop synchronizer for one PS/2 pin, plus a falling-edge detector on the
// synchronized level. The keyboard receiver uses the same block.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   din    in  raw, asynchronous pin level
//   level  out synchronized pin level
//   fall   out high for one cycle after the synchronized level drops 1->0
// ---------------------------------------------------------------------------
import ps2_pkg::*;

module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic fall
);

  logic meta;
  logic level_prev;

  // The flops reset to 1 because an idle PS/2 line is pulled high. Resetting
  // them low would produce a bogus falling edge right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta       <= 1'b1;
      level      <= 1'b1;
      level_prev <= 1'b1;
    end else begin
      meta       <= din;
      level      <= meta;
      level_prev <= level;
    end
  end

  assign fall = level_prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter. It sends one command byte to the keyboard
// by pulling the open-drain clock and data lines through output enables. It
// then follows the device-generated clock, checks the device ACK, and reports
// the result as a done or error pulse.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-high reset
//   tx_data   in  command byte, taken when tx_valid & tx_ready
//   tx_valid  in  send request
//   tx_ready  out high only while idle
//   tx_done   out one-cycle pulse: frame sent and ACK seen
//   tx_error  out one-cycle pulse: watchdog timeout or missing ACK
//   busy      out high whenever not idle (receiver ignores the lines)
//   ps2c_in   in  raw PS/2 clock pin
//   ps2d_in   in  raw PS/2 data pin
//   ps2c_oe   out 1 = pull clock line low
//   ps2d_oe   out 1 = pull data line low
// ---------------------------------------------------------------------------
import ps2_pkg::*;

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT     = 4'(FRAME_BITS - 1);

  state_t        state;
  logic [9:0]    frame;
  logic [3:0]    bitcnt;
  logic [CW-1:0] cnt;
  logic          sync_clk;
  logic          sync_data;
  logic          clk_fall;
  logic          data_fall;
  logic          wd_expired;

  ps2_sync_edge u_sync_clk (
    .clk   (clk),
    .reset (reset),
    .din   (ps2c_in),
    .level (sync_clk),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk   (clk),
    .reset (reset),
    .din   (ps2d_in),
    .level (sync_data),
    .fall  (data_fall)
  );

  assign tx_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign wd_expired = (cnt == TIMEOUT_LAST);

  // One counter serves two purposes. In INHIBIT it times the clock-low
  // period. In the device-clocked states it is the watchdog, which every
  // device clock fall clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      frame    <= '0;
      bitcnt   <= '0;
      cnt      <= '0;
      ps2c_oe  <= 1'b0;
      ps2d_oe  <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      unique case (state)
        IDLE: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          if (tx_valid) begin
            frame   <= {1'b1, odd_parity(tx_data), tx_data};
            ps2c_oe <= 1'b1;
            cnt     <= '0;
            bitcnt  <= '0;
            state   <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INHIBIT_LAST) begin
            ps2d_oe <= 1'b1;
            state   <= RTS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RTS: begin
          // Release the clock and keep data low. The low data line is the
          // start bit, which tells the device to begin clocking.
          ps2c_oe <= 1'b0;
          bitcnt  <= '0;
          cnt     <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (clk_fall) begin
            cnt <= '0;
            if (bitcnt < 4'(FRAME_BITS)) begin
              ps2d_oe <= ~frame[bitcnt];
              bitcnt  <= bitcnt + 1'b1;
              if (bitcnt == LAST_BIT) begin
                state <= ACK;
              end
            end
          end else if (wd_expired) begin
            ps2c_oe  <= 1'b0;
            ps2d_oe  <= 1'b0;
            tx_error <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK: begin
          if (clk_fall) begin
            cnt <= '0;
            if (!sync_data) begin
              state <= WAIT_IDLE;
            end else begin
              tx_error <= 1'b1;
              state    <= IDLE;
            end
          end else if (wd_expired) begin
            ps2c_oe  <= 1'b0;
            ps2d_oe  <= 1'b0;
            tx_error <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // The frame ends only after the device lets both lines go high.
          // This keeps the receiver from seeing the tail of the ACK.
          if (sync_clk && sync_data) begin
            tx_done <= 1'b1;
            state   <= IDLE;
          end else if (clk_fall) begin
            cnt <= '0;
          end else if (wd_expired) begin
            ps2c_oe  <= 1'b0;
            ps2d_oe  <= 1'b0;
            tx_error <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
